// File: rtl/cook_program_sequencer.sv
// Multi-stage cook program sequencer: drives the external BCD timer and gates the magnetron by power duty cycle.
// Optional end-of-program chime enabled by defining CHIME_EN.
module cook_program_sequencer #(
  parameter int NSTAGES   = 4,
  parameter int STAGE_W   = 2,
  parameter int WINDOW    = 10,
  parameter int CHIME_LEN = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               prog_we,
  input  logic [STAGE_W-1:0] prog_addr,
  input  logic [11:0]        prog_time,
  input  logic [3:0]         prog_power,
  input  logic [STAGE_W:0]   prog_count,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               sec_tick,
  input  logic               timer_zero,
  output logic               timer_load,
  output logic [11:0]        timer_load_val,
  output logic               timer_dec,
  output logic               mag_on,
  output logic [STAGE_W-1:0] stage_idx,
  output logic               busy,
  output logic               done,
  output logic               chime
);
  // Window counter shares the 4-bit width of power, so WINDOW must not exceed 16.
  localparam int WIN_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COOK, S_PAUSE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [11:0]        time_q [NSTAGES];
  logic [3:0]         pow_q  [NSTAGES];
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [STAGE_W:0]   total_q, total_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               mag_q, mag_d;
  logic               arm_q, arm_d;
  logic               start_used;

  logic hold, go_ok, cnt_ok, last;
  assign hold   = ~door_closed | ~stopn;
  // arm_q blocks a held-low startn from retriggering after it has been consumed once
  assign go_ok  = ~startn & door_closed & arm_q;
  assign cnt_ok = (prog_count != '0) && (prog_count <= (STAGE_W+1)'(NSTAGES));
  assign last   = ({1'b0, stage_q} == total_q - 1'b1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      total_q <= '0;
      win_q   <= '0;
      mag_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      total_q <= total_d;
      win_q   <= win_d;
      mag_q   <= mag_d;
      arm_q   <= arm_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NSTAGES; i++) begin
        time_q[i] <= '0;
        pow_q[i]  <= '0;
      end
    end else if (prog_we && state_q == S_IDLE &&
                 ({1'b0, prog_addr} < (STAGE_W+1)'(NSTAGES))) begin
      time_q[prog_addr] <= prog_time;
      pow_q[prog_addr]  <= prog_power;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    total_d    = total_q;
    win_d      = win_q;
    start_used = 1'b0;
    case (state_q)
      S_IDLE: if (clearn && !hold && go_ok && cnt_ok) begin
        state_d    = S_LOAD;
        stage_d    = '0;
        total_d    = prog_count;
        start_used = 1'b1;
      end
      S_LOAD: begin
        win_d = '0;
        if (!clearn) begin
          state_d = S_IDLE;
          stage_d = '0;
        end else if (hold) state_d = S_PAUSE;
        else               state_d = S_COOK;
      end
      S_COOK: begin
        if (!clearn) begin
          state_d = S_IDLE;
          stage_d = '0;
        end else if (hold) begin
          state_d = S_PAUSE;
        end else if (timer_zero) begin
          if (last) state_d = S_DONE;
          else begin
            state_d = S_LOAD;
            stage_d = stage_q + 1'b1;
          end
        end else if (sec_tick) begin
          win_d = (win_q == WIN_W'(WINDOW-1)) ? '0 : win_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (!clearn) begin
          state_d = S_IDLE;
          stage_d = '0;
        end else if (!hold && go_ok) begin
          state_d    = S_COOK;
          start_used = 1'b1;
        end
      end
      S_DONE: begin
        if (!clearn || !door_closed) begin
          state_d = S_IDLE;
          stage_d = '0;
        end else if (stopn && go_ok) begin
          state_d    = S_IDLE;
          stage_d    = '0;
          start_used = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    arm_d = startn ? 1'b1 : (start_used ? 1'b0 : arm_q);
    // registered from next state so mag_on tracks COOK exactly; power >= WINDOW is always on
    mag_d = (state_d == S_COOK) && door_closed && (win_d < pow_q[stage_d]);
  end

  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = '0;
    timer_dec      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      S_LOAD: begin
        timer_load     = 1'b1;
        timer_load_val = time_q[stage_q];
        busy           = 1'b1;
      end
      S_COOK: begin
        busy      = 1'b1;
        timer_dec = clearn & ~hold & ~timer_zero & sec_tick;
      end
      S_PAUSE: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign mag_on    = mag_q;
  assign stage_idx = stage_q;

`ifdef CHIME_EN
  localparam int CW = $clog2(CHIME_LEN + 1);
  logic          chime_q;
  logic [CW-1:0] ccnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chime_q <= 1'b0;
      ccnt_q  <= '0;
    end else if (state_d == S_DONE && state_q != S_DONE) begin
      chime_q <= 1'b1;
      ccnt_q  <= '0;
    end else if (state_d != S_DONE) begin
      chime_q <= 1'b0;
    end else if (chime_q && sec_tick) begin
      if (ccnt_q == CW'(CHIME_LEN-1)) chime_q <= 1'b0;
      ccnt_q <= ccnt_q + 1'b1;
    end
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif
endmodule

// File: doc/cook_program_sequencer.md
Name: cook_program_sequencer

Overview:
- Multi-stage cook-program controller for the microwave countdown/magnetron datapath.
- Stores up to NSTAGES (time, power) stages, loads each stage time into the external BCD countdown timer and issues per-second decrement strobes.
- Gates mag_on with a power-level duty cycle over a WINDOW-second window.
- Sits between keypad/button front end and the existing timer + seven-segment path; front end writes stage table, sequencer runs it.

Parameters:
NSTAGES, 4, number of program stages (stage index width STAGE_W)
STAGE_W, 2, width of stage index/address
WINDOW, 10, duty-cycle window length in seconds; power 1..WINDOW
CHIME_LEN, 3, chime length in sec_tick periods (CHIME_EN only)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  async active-low reset
prog_we  input  1  stage-table write strobe (honoured only in IDLE)
prog_addr  input  STAGE_W  stage written
prog_time  input  12  stage time BCD {min, sec_tens, sec_ones}
prog_power  input  4  stage power 0..10 (0 = stand/rest, magnetron off)
prog_count  input  STAGE_W+1  stages to run, 1..NSTAGES (sampled at start)
startn  input  1  start/resume, active low
stopn  input  1  pause, active low
clearn  input  1  abort to IDLE, active low
door_closed  input  1  1 = door shut
sec_tick  input  1  one-cycle pulse once per second
timer_zero  input  1  external timer value == 0
timer_load  output  1  one-cycle load strobe to timer
timer_load_val  output  12  BCD value to load
timer_dec  output  1  one-cycle decrement strobe to timer
mag_on  output  1  magnetron enable
stage_idx  output  STAGE_W  current stage
busy  output  1  state is LOAD, COOK or PAUSE
done  output  1  state is DONE
chime  output  1  end-of-program chime (0 without CHIME_EN)

Behaviour:
- Reset (async, resetn=0): state IDLE; stage table time=0, power=0; all outputs 0; stage_idx=0; window count 0; latched stage total 0.
- All other inputs sampled synchronously; priority every cycle: clearn > (door_closed=0 or stopn=0) > startn > sec_tick/timer_zero.
- IDLE: prog_we writes table[prog_addr]; prog_count=0 or >NSTAGES ignored. startn=0 & door_closed=1 & prog_count valid -> latch total, stage_idx=0 -> LOAD. Writes outside IDLE ignored.
- LOAD (1 cycle): timer_load=1, timer_load_val=table[stage_idx].time, window count cleared -> COOK. Timer captures on this edge; timer_zero valid from next cycle.
- COOK: timer_zero=1 -> stage ends same cycle; no dec. If stage_idx<total-1: stage_idx+1 -> LOAD. Else -> DONE. A 0-second stage therefore costs LOAD+1 cycle.
- COOK, else on sec_tick: timer_dec=1; window count = (count==WINDOW-1)?0:count+1.
- COOK, stopn=0 or door_closed=0 -> PAUSE; a sec_tick in that cycle is dropped.
- mag_on = (state==COOK) & door_closed & (window count < power); power>WINDOW saturates to always on. mag_on is registered and drops in the cycle state leaves COOK.
- PAUSE: mag_on=0, no dec; timer and window count held. startn=0 & door_closed=1 -> COOK (resume, no reload).
- DONE: done=1, busy=0. clearn=0, startn=0 or door_closed=0 -> IDLE.
- clearn=0 in any non-IDLE state -> IDLE next edge; stage_idx=0; table retained; timer not reloaded.
- Reset mid-program: immediate IDLE, table cleared.
- startn held low: no retrigger from DONE->IDLE->LOAD without startn first returning high.

Optional Feature:
- CHIME_EN defined: on entry to DONE chime=1 until CHIME_LEN sec_ticks have been counted in DONE, or until DONE is exited.
- Not defined: chime tied 0, no counter logic.

Test Plan:
- Write stage0 {0,1,0}/power 10, prog_count=1; startn pulse -> timer_load with 0x010, 10 timer_dec over 10 sec_ticks, mag_on high throughout, timer_zero -> done=1.
- Stage0 {0,2,0}/power 3 -> per 10-tick window mag_on high for ticks 0-2, low for 3-9; exactly 20 timer_dec.
- Two stages {0,0,5}/p10 then {0,0,3}/p0 -> two timer_load pulses (0x005, 0x003), stage_idx 0 then 1, mag_on low in stage 1, done after 8 decs.
- stopn at tick 4 of 10, sec_tick same cycle -> no dec that cycle, PAUSE, mag_on 0; startn -> resume, 6 more decs, no reload.
- Door opens in COOK -> PAUSE; startn with door_closed=0 ignored; door shut + startn -> resume. clearn in PAUSE -> IDLE, table retained.
- Zero-time stage {0,0,0} between two stages -> skipped in 2 cycles, no dec. With CHIME_EN: chime high for 3 sec_ticks after done.
